// File: rtl/kyber_pkg.sv
// +--------------------------------------------------------------------+
// | kyber_pkg : shared Kyber constants and poly_pack_writer FSM states |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
`default_nettype none

package kyber_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int COEF_W  = 12;
    localparam int LANES   = 8;
    localparam int ADDR_W  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } pp_state_t;

endpackage

`default_nettype wire

// File: rtl/coef_reduce.sv
// +--------------------------------------------------------------------+
// | coef_reduce : single conditional subtract of KYBER_Q               |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

module coef_reduce #(
    parameter int W = kyber_pkg::COEF_W
) (
    input  logic [W-1:0] coef_in,
    output logic [W-1:0] coef_out
);

    import kyber_pkg::*;

    always_comb begin
        coef_out = coef_in;
        if (coef_in >= W'(KYBER_Q)) begin
            coef_out = coef_in - W'(KYBER_Q);
        end
    end

endmodule

`default_nettype wire

// File: rtl/poly_pack_writer.sv
// +--------------------------------------------------------------------+
// | poly_pack_writer : packs 8 coefficients per word, writes RAM port A|
// | Option: POLY_PACK_REDUCE_EN reduces each coefficient mod KYBER_Q   |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module poly_pack_writer #(
    parameter int COEF_W  = kyber_pkg::COEF_W,
    parameter int LANES   = kyber_pkg::LANES,
    parameter int ADDR_W  = kyber_pkg::ADDR_W,
    parameter int N_WORDS = kyber_pkg::KYBER_N / kyber_pkg::LANES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic                      in_valid,
    input  logic [COEF_W-1:0]         in_coef,
    output logic                      in_ready,
    output logic                      wena,
    output logic [ADDR_W-1:0]         waddra,
    output logic [COEF_W*LANES-1:0]   dina,
    output logic                      busy,
    output logic                      done
);

    import kyber_pkg::*;

    localparam int LANE_W = $clog2(LANES);
    localparam int WORD_W = $clog2(N_WORDS);

    pp_state_t                     r_state;
    pp_state_t                     w_state_nxt;
    logic [LANE_W-1:0]             r_lane;
    logic [WORD_W-1:0]             r_word;
    logic [ADDR_W-1:0]             r_base;
    logic [LANES-1:0][COEF_W-1:0]  r_asm;
    logic [LANES-1:0][COEF_W-1:0]  w_word;
    logic [COEF_W-1:0]             w_coef;
    logic                          w_accept;
    logic                          w_last_lane;
    logic                          w_last_word;

`ifdef POLY_PACK_REDUCE_EN
    coef_reduce #(
        .W (COEF_W)
    ) u_reduce (
        .coef_in  (in_coef),
        .coef_out (w_coef)
    );
`else
    assign w_coef = in_coef;
`endif

    // in_ready is a flop that mirrors "state is LOAD", so it is safe as a qualifier
    assign w_accept    = in_valid && in_ready;
    assign w_last_lane = (r_lane == LANE_W'(LANES - 1));
    assign w_last_word = (r_word == WORD_W'(N_WORDS - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept && w_last_lane && w_last_word) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Current word with the incoming coefficient merged into its lane
    always_comb begin
        w_word         = r_asm;
        w_word[r_lane] = w_coef;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane   <= '0;
            r_word   <= '0;
            r_base   <= '0;
            r_asm    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            wena     <= 1'b0;
            waddra   <= '0;
            dina     <= '0;
            done     <= 1'b0;
        end else begin
            wena     <= 1'b0;
            done     <= 1'b0;
            in_ready <= (w_state_nxt == ST_LOAD);
            busy     <= (w_state_nxt == ST_LOAD);

            if ((r_state == ST_IDLE) && start) begin
                r_base <= base_addr;
                r_lane <= '0;
                r_word <= '0;
            end

            if (w_accept) begin
                r_asm  <= w_word;
                r_lane <= w_last_lane ? '0 : r_lane + LANE_W'(1);
                if (w_last_lane) begin
                    dina   <= w_word;
                    waddra <= r_base + ADDR_W'(r_word);
                    wena   <= 1'b1;
                    done   <= w_last_word;
                    r_word <= r_word + WORD_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/poly_pack_writer.md
# poly_pack_writer

Upstream write stage for the 96x1024 coefficient RAM. Accepts a valid/ready stream of 12-bit polynomial coefficients, packs eight per 96-bit word, and drives the RAM's port-A write interface (wena/waddra/dina) for one 256-coefficient polynomial per start command. Sits between the sampler/decoder front end and the coefficient RAM.

## Interface
- COEF_W, 12, coefficient width
- LANES, 8, coefficients per RAM word (data width = COEF_W*LANES = 96)
- ADDR_W, 10, RAM address width
- N_WORDS, 32, words per polynomial (256 coefficients)
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle command; sampled only in IDLE
- base_addr  input  ADDR_W  first RAM word address, captured on accepted start
- in_valid  input  1  coefficient valid
- in_coef  input  COEF_W  coefficient
- in_ready  output  1  block accepts coefficient this cycle
- wena  output  1  RAM write enable (to port A)
- waddra  output  ADDR_W  RAM write address
- dina  output  COEF_W*LANES  RAM write data
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse when last word is written

## Operation
- States: IDLE, LOAD.
- IDLE: in_ready=0, busy=0. start=1 -> capture base_addr, clear lane and word counters, go LOAD.
- LOAD: in_ready=1, busy=1. Handshake: coefficient accepted when in_valid&&in_ready.
- Accepted coefficient k (lane counter 0..7) stored at bits [12k+11:12k] of the assembly register.
- On acceptance with lane=7: full word (including this coefficient) copied to dina register, waddra <= base + word_cnt (mod 2^ADDR_W), wena <= 1 for exactly one cycle; lane wraps to 0, word_cnt increments.
- Assembly register and output register are separate: accepting the next coefficient during the write cycle is allowed; no bubble is required.
- When word N_WORDS-1 is issued: FSM returns to IDLE on that same edge (in_ready=0 next cycle); done=1 in the cycle wena=1 for that last word.
- start during LOAD ignored. in_valid during IDLE ignored (not consumed).
- Address wrap: base_addr+31 beyond 1023 wraps to low addresses; no alignment required.
- Reset (any time, including mid-polynomial): all state cleared immediately, partial word discarded, no write issued.

## Timing
- Reset values: in_ready=0, wena=0, waddra=0, dina=0, busy=0, done=0, FSM=IDLE.
- in_ready rises one cycle after accepted start.
- Latency: 8th coefficient of a word accepted at edge N -> wena=1, waddra/dina valid in cycle after edge N (one cycle).
- Max throughput: one coefficient per cycle; 256 coefficients -> 32 writes, done 1 cycle after final accept; start-to-done minimum 258 cycles.
- wena, waddra, dina, done, in_ready, busy all registered outputs.
- dina/waddra hold last value when wena=0.

## Configuration
- POLY_PACK_REDUCE_EN defined: each accepted coefficient passes through a single conditional subtract (c>=3329 -> c-3329) before storing; all 12-bit inputs land in [0,3328]. Purely combinational on input path, no latency change.
- Undefined: coefficients stored unchanged.

## Structure
- Shared package kyber_pkg: KYBER_Q=3329, KYBER_N=256, COEF_W, LANES, ADDR_W, state enum for this FSM.
- One sub-module: coef_reduce (conditional subtract by KYBER_Q), instantiated only under POLY_PACK_REDUCE_EN.

## Test plan
- start with base_addr=0x040, stream coefficients 0..255 continuously -> 32 single-cycle writes at 0x040..0x05F, word j lane k = 8j+k, done in same cycle as write to 0x05F, busy low next cycle.
- in_valid toggling 1/0 every cycle -> identical RAM contents, writes spaced 16 cycles, no lost or duplicated coefficient.
- base_addr=0x3F0 -> writes 0x3F0..0x3FF then 0x000..0x00F.
- rst_n low after 100 accepted coefficients -> all outputs zero immediately; new start writes only new data, no stray wena.
- start pulsed during LOAD and in_valid during IDLE -> no effect on address, counters, or contents.
- POLY_PACK_REDUCE_EN: inputs 3328, 3329, 4095 -> stored 3328, 0, 766; without macro stored 3328, 3329, 4095.
